// File: rtl/player_bullet.sv
// player_bullet: single player projectile that launches on fire, climbs one step per frame,
// retires on an enemy hit or at the top of the screen, then waits out a frame cooldown.
module player_bullet #(
    parameter logic [11:0] color_p         = {4'hF, 4'hF, 4'h0},
    parameter int          BULLET_W        = 4,
    parameter int          BULLET_H        = 10,
    parameter int          SPEED           = 6,
    parameter int          PLAYER_W        = 40,
    parameter int          PLAYER_Y        = 440,
    parameter int          COOLDOWN_FRAMES = 15
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_i,
    input  logic [9:0] sx_i,
    input  logic [9:0] sy_i,
    input  logic       de_i,
    input  logic       fire_i,
    input  logic [9:0] player_x_i,
    input  logic       hit_i,
    output logic       bullet_area_o,
    output logic [3:0] bullet_r_o,
    output logic [3:0] bullet_g_o,
    output logic [3:0] bullet_b_o,
    output logic       active_o,
    output logic [9:0] bullet_x_o,
    output logic [9:0] bullet_y_o,
    output logic [7:0] shots_o,
    output logic [7:0] hits_o
);
    localparam int CW = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [9:0] x_off   = 10'(PLAYER_W / 2 - BULLET_W / 2);
    localparam logic [9:0] spawn_y = 10'(PLAYER_Y - BULLET_H);
    localparam logic [9:0] speed   = 10'(SPEED);

    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

    state_t        state;
    logic [9:0]    bx, by;
    logic [CW-1:0] cnt;
    logic          fire_q, fire_req, rise;
    logic [10:0]   x_end, y_end;

    assign rise  = fire_i & ~fire_q;
    // 11-bit extents so a bullet near column/row 1023 does not wrap its own span
    assign x_end = {1'b0, bx} + 11'(BULLET_W);
    assign y_end = {1'b0, by} + 11'(BULLET_H);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state    <= IDLE;
            bx       <= '0;
            by       <= '0;
            cnt      <= '0;
            shots_o  <= '0;
            hits_o   <= '0;
            fire_req <= 1'b0;
            fire_q   <= 1'b1;
        end else begin
            fire_q <= fire_i;
            case (state)
                IDLE: begin
                    if (frame_i && (fire_req || rise)) begin
                        bx       <= player_x_i + x_off;
                        by       <= spawn_y;
                        fire_req <= 1'b0;
                        shots_o  <= shots_o + {7'd0, shots_o != 8'hFF};
                        state    <= FLYING;
                    end else if (rise) begin
                        fire_req <= 1'b1;
                    end
                end
                FLYING: begin
                    if (hit_i) begin
                        hits_o <= hits_o + {7'd0, hits_o != 8'hFF};
                        cnt    <= CW'(COOLDOWN_FRAMES);
                        state  <= COOLDOWN;
                    end else if (frame_i) begin
                        if (by < speed) begin
                            cnt   <= CW'(COOLDOWN_FRAMES);
                            state <= COOLDOWN;
                        end else begin
                            by <= by - speed;
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_i) begin
                        if (cnt == '0) state <= IDLE;
                        else cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active_o      = state == FLYING;
    assign bullet_area_o = active_o && de_i
                         && sx_i >= bx && {1'b0, sx_i} < x_end
                         && sy_i >= by && {1'b0, sy_i} < y_end;
    assign bullet_r_o    = color_p[11:8];
    assign bullet_g_o    = color_p[7:4];
    assign bullet_b_o    = color_p[3:0];
    assign bullet_x_o    = bx;
    assign bullet_y_o    = by;
endmodule
